// File: rtl/bresen_line_gen.sv
// bresen_line_gen: Bresenham line rasteriser.
//   Accepts one endpoint pair (x0,y0)->(x1,y1) on a valid/ready command port.
//   After a one-cycle setup it emits one pixel per cycle on a valid/ready
//   pixel stream. Both endpoints are emitted.
// Ports:
//   clk, n_rst            clock, async active-low reset
//   cmd_valid/cmd_ready   command handshake; x0,y0,x1,y1 are latched on accept
//   abort                 drops the current line (SETUP/DRAW), no line_done
//   pix_valid/pix_ready   pixel handshake; pix_x, pix_y, pix_addr={x,y}, pix_last
//   busy                  high whenever not IDLE
//   line_done             one-cycle pulse after the last pixel is accepted
module bresen_line_gen #(
  parameter int X_W   = 10,
  parameter int Y_W   = 9,
  parameter int ERR_W = ((X_W > Y_W) ? X_W : Y_W) + 2
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [X_W-1:0]     x0,
  input  logic [Y_W-1:0]     y0,
  input  logic [X_W-1:0]     x1,
  input  logic [Y_W-1:0]     y1,
  input  logic               abort,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [X_W-1:0]     pix_x,
  output logic [Y_W-1:0]     pix_y,
  output logic [X_W+Y_W-1:0] pix_addr,
  output logic               pix_last,
  output logic               busy,
  output logic               line_done
);

  typedef enum logic [1:0] {IDLE, SETUP, DRAW} state_e;

  localparam logic [X_W-1:0] X_ONE = X_W'(1);
  localparam logic [Y_W-1:0] Y_ONE = Y_W'(1);

  state_e                  state_q, state_d;
  logic [X_W-1:0]          x0_q, x0_d, x1_q, x1_d, x_q, x_d;
  logic [Y_W-1:0]          y0_q, y0_d, y1_q, y1_d, y_q, y_d;
  logic signed [ERR_W-1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
  // Step direction flags: 1 means decrement.
  logic                    sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
  logic                    line_done_q, line_done_d;

  logic [X_W-1:0]          adx;
  logic [Y_W-1:0]          ady;
  logic signed [ERR_W-1:0] dx_abs, dy_abs, e2, err_nx;
  logic                    at_end;

  assign at_end    = (x_q == x1_q) && (y_q == y1_q);
  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign pix_valid = (state_q == DRAW);
  assign pix_last  = (state_q == DRAW) && at_end;
  assign pix_x     = x_q;
  assign pix_y     = y_q;
  assign pix_addr  = {x_q, y_q};
  assign line_done = line_done_q;

  always_comb begin
    state_d     = state_q;
    x0_d        = x0_q;
    y0_d        = y0_q;
    x1_d        = x1_q;
    y1_d        = y1_q;
    x_d         = x_q;
    y_d         = y_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    err_d       = err_q;
    sx_neg_d    = sx_neg_q;
    sy_neg_d    = sy_neg_q;
    line_done_d = 1'b0;

    adx    = (x1_q >= x0_q) ? (x1_q - x0_q) : (x0_q - x1_q);
    ady    = (y1_q >= y0_q) ? (y1_q - y0_q) : (y0_q - y1_q);
    dx_abs = {{(ERR_W-X_W){1'b0}}, adx};
    dy_abs = {{(ERR_W-Y_W){1'b0}}, ady};
    // Both step tests use the same doubled error; contributions are summed.
    e2     = err_q <<< 1;
    err_nx = err_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          x0_d    = x0;
          y0_d    = y0;
          x1_d    = x1;
          y1_d    = y1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          dx_d     = dx_abs;
          dy_d     = -dy_abs;
          sx_neg_d = (x1_q < x0_q);
          sy_neg_d = (y1_q < y0_q);
          err_d    = dx_abs - dy_abs;
          x_d      = x0_q;
          y_d      = y0_q;
          state_d  = DRAW;
        end
      end
      DRAW: begin
        if (abort) begin
          state_d = IDLE;
        end else if (pix_ready) begin
          if (at_end) begin
            state_d     = IDLE;
            line_done_d = 1'b1;
          end else begin
            if (e2 >= dy_q) begin
              x_d    = sx_neg_q ? (x_q - X_ONE) : (x_q + X_ONE);
              err_nx = err_nx + dy_q;
            end
            if (e2 <= dx_q) begin
              y_d    = sy_neg_q ? (y_q - Y_ONE) : (y_q + Y_ONE);
              err_nx = err_nx + dx_q;
            end
            err_d = err_nx;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      x0_q        <= '0;
      y0_q        <= '0;
      x1_q        <= '0;
      y1_q        <= '0;
      x_q         <= '0;
      y_q         <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      err_q       <= '0;
      sx_neg_q    <= 1'b0;
      sy_neg_q    <= 1'b0;
      line_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x0_q        <= x0_d;
      y0_q        <= y0_d;
      x1_q        <= x1_d;
      y1_q        <= y1_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      err_q       <= err_d;
      sx_neg_q    <= sx_neg_d;
      sy_neg_q    <= sy_neg_d;
      line_done_q <= line_done_d;
    end
  end

endmodule

// File: tb/tb_bresen_line_gen.sv
module tb_bresen_line_gen;
  localparam int X_W = 10;
  localparam int Y_W = 9;

  logic               clk = 1'b0;
  logic               n_rst = 1'b0;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [X_W-1:0]     x0 = '0, x1 = '0;
  logic [Y_W-1:0]     y0 = '0, y1 = '0;
  logic               abort = 1'b0;
  logic               pix_valid;
  logic               pix_ready = 1'b0;
  logic [X_W-1:0]     pix_x;
  logic [Y_W-1:0]     pix_y;
  logic [X_W+Y_W-1:0] pix_addr;
  logic               pix_last;
  logic               busy;
  logic               line_done;

  int vectors = 0;
  int miscompares = 0;

  logic [X_W-1:0] ex_x[$];
  logic [Y_W-1:0] ex_y[$];

  bresen_line_gen #(.X_W(X_W), .Y_W(Y_W)) dut (
    .clk(clk), .n_rst(n_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .abort(abort),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_addr(pix_addr), .pix_last(pix_last),
    .busy(busy), .line_done(line_done)
  );

  always #5 clk = ~clk;

  // Reference: textbook integer Bresenham over all octants.
  task automatic build_ref(input int ax0, input int ay0, input int ax1, input int ay1);
    int x, y, dx, dy, sx, sy, err, e2;
    ex_x.delete();
    ex_y.delete();
    dx  = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
    dy  = -((ay1 > ay0) ? ay1 - ay0 : ay0 - ay1);
    sx  = (ax1 >= ax0) ? 1 : -1;
    sy  = (ay1 >= ay0) ? 1 : -1;
    err = dx + dy;
    x = ax0;
    y = ay0;
    forever begin
      ex_x.push_back(X_W'(x));
      ex_y.push_back(Y_W'(y));
      if (x == ax1 && y == ay1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endtask

  // Issue a command and follow the line. ready_pct: random pix_ready rate.
  // stall_at: pixel index at which pix_ready is forced low for 3 cycles.
  // abort_at: pixel index on which abort is asserted (-1 = none).
  task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1,
                          input int ready_pct, input int stall_at, input int abort_at);
    int n, idx, cyc, stalls, want_cnt, adx, ady;
    bit done, rdy;
    build_ref(ax0, ay0, ax1, ay1);
    n = ex_x.size();
    adx = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
    ady = (ay1 > ay0) ? ay1 - ay0 : ay0 - ay1;
    want_cnt = ((adx > ady) ? adx : ady) + 1;

    cmd_valid = 1'b1;
    x0 = X_W'(ax0); y0 = Y_W'(ay0); x1 = X_W'(ax1); y1 = Y_W'(ay1);
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL cmd_ready got=%b want=1", cmd_ready);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    vectors++;
    if (pix_valid !== 1'b0 || busy !== 1'b1 || line_done !== 1'b0 || cmd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL setup_cycle got v=%b busy=%b done=%b rdy=%b want v=0 busy=1 done=0 rdy=0",
               pix_valid, busy, line_done, cmd_ready);
    end
    @(posedge clk); #1;
    vectors++;
    if (pix_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL first_pixel_latency got pix_valid=%b want=1", pix_valid);
    end

    idx = 0; cyc = 0; stalls = 3; done = 0;
    while (!done) begin
      if (cyc > 8 * n + 50) begin
        vectors++;
        miscompares++;
        $display("FAIL line_timeout got pixels=%0d want=%0d", idx, n);
        break;
      end
      vectors++;
      if (pix_valid !== 1'b1 || pix_x !== ex_x[idx] || pix_y !== ex_y[idx] ||
          pix_addr !== {ex_x[idx], ex_y[idx]} || pix_last !== (idx == n - 1)) begin
        miscompares++;
        $display("FAIL pixel[%0d] got v=%b (%0d,%0d) addr=%h last=%b want v=1 (%0d,%0d) addr=%h last=%b",
                 idx, pix_valid, pix_x, pix_y, pix_addr, pix_last,
                 ex_x[idx], ex_y[idx], {ex_x[idx], ex_y[idx]}, (idx == n - 1));
      end
      rdy = ($urandom_range(99) < ready_pct);
      if (idx == stall_at && stalls > 0) begin rdy = 0; stalls--; end
      pix_ready = rdy;
      if (idx == abort_at) abort = 1'b1;
      @(posedge clk); #1;
      cyc++;
      if (abort) begin
        abort = 1'b0;
        pix_ready = 1'b0;
        vectors++;
        if (pix_valid !== 1'b0 || line_done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
          miscompares++;
          $display("FAIL abort got v=%b done=%b rdy=%b busy=%b want v=0 done=0 rdy=1 busy=0",
                   pix_valid, line_done, cmd_ready, busy);
        end
        @(posedge clk); #1;
        vectors++;
        if (line_done !== 1'b0) begin
          miscompares++;
          $display("FAIL abort_no_done got line_done=%b want=0", line_done);
        end
        return;
      end
      if (rdy) begin
        if (idx == n - 1) done = 1;
        else idx++;
      end
    end
    pix_ready = 1'b0;
    if (done) begin
      vectors++;
      if (line_done !== 1'b1 || cmd_ready !== 1'b1 || pix_valid !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL line_done_cycle got done=%b rdy=%b v=%b busy=%b want done=1 rdy=1 v=0 busy=0",
                 line_done, cmd_ready, pix_valid, busy);
      end
      vectors++;
      if (idx + 1 != want_cnt) begin
        miscompares++;
        $display("FAIL pixel_count got=%0d want=%0d", idx + 1, want_cnt);
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    vectors++;
    if (cmd_ready !== 1'b1 || pix_valid !== 1'b0 || pix_x !== '0 || pix_y !== '0 ||
        pix_last !== 1'b0 || busy !== 1'b0 || line_done !== 1'b0) begin
      miscompares++;
      $display("FAIL %s got rdy=%b v=%b x=%0d y=%0d last=%b busy=%b done=%b want 1 0 0 0 0 0 0",
               tag, cmd_ready, pix_valid, pix_x, pix_y, pix_last, busy, line_done);
    end
  endtask

  task automatic test_reset;
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset_state");
    n_rst = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("post_reset_idle");
  endtask

  task automatic test_directed;
    run_line(0, 0, 3, 0, 100, -1, -1);
    run_line(0, 0, 4, 2, 100, -1, -1);
    run_line(5, 5, 2, 2, 100, -1, -1);
    run_line(1, 0, 1, 3, 100, -1, -1);
    run_line(7, 9, 7, 9, 100, -1, -1);
  endtask

  task automatic test_backpressure;
    run_line(0, 0, 3, 0, 100, 1, -1);
    run_line(10, 3, 2, 8, 50, 2, -1);
  endtask

  task automatic test_abort;
    run_line(0, 0, 9, 0, 100, -1, 1);
    run_line(2, 6, 0, 0, 100, -1, -1);
  endtask

  task automatic test_async_reset;
    cmd_valid = 1'b1;
    x0 = '0; y0 = '0; x1 = X_W'(9); y1 = '0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    pix_ready = 1'b1;
    repeat (4) @(posedge clk);
    #3;
    n_rst = 1'b0;
    #1;
    check_reset_vals("async_reset_immediate");
    pix_ready = 1'b0;
    @(posedge clk); #2;
    n_rst = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("after_reset_release");
    run_line(3, 1, 0, 4, 100, -1, -1);
  endtask

  task automatic test_random;
    for (int i = 0; i < 30; i++) begin
      run_line($urandom_range(40), $urandom_range(40), $urandom_range(40), $urandom_range(40),
               40 + $urandom_range(60), -1, -1);
    end
    for (int i = 0; i < 3; i++) begin
      run_line($urandom_range(1023), $urandom_range(511), $urandom_range(1023), $urandom_range(511),
               100, -1, -1);
    end
  endtask

  task automatic test_back_to_back;
    // run_line returns in the line_done cycle, so the next command is
    // presented exactly in that cycle.
    run_line(0, 0, 2, 1, 100, -1, -1);
    run_line(4, 0, 0, 0, 100, -1, -1);
    run_line(0, 3, 0, 0, 100, -1, -1);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_abort();
    test_async_reset();
    test_back_to_back();
    test_random();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
